// File: rtl/cat_read_sequencer.sv
// Reads a completed cat2 vector out of the upstream buffer in fixed-width
// windows and streams them as valid/ready beats with an end-of-vector flag.
module cat_read_sequencer #(
    parameter int NBits           = 8,
    parameter int VecElements     = 6,
    parameter int ElementsPerRead = 2
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  cat_valid,
    output logic                                  rd_en,
    input  logic [ElementsPerRead-1:0][NBits-1:0] rd_data,
    input  logic                                  clear,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [ElementsPerRead-1:0][NBits-1:0] m_data,
    output logic                                  m_last,
    output logic [15:0]                           vec_count,
    output logic                                  busy
);

    localparam int Beats = VecElements / ElementsPerRead;
    localparam int CW    = $clog2(Beats) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                                r_state;
    state_t                                w_next;
    logic [CW-1:0]                         r_beat_cnt;
    logic                                  r_m_valid;
    logic                                  r_m_last;
    logic [ElementsPerRead-1:0][NBits-1:0] r_m_data;
    logic [15:0]                           r_vec_count;
    logic                                  w_rd_en;
    logic                                  w_xfer;
    logic                                  w_last_load;
    logic                                  w_done;

    assign w_xfer      = r_m_valid & m_ready;
    assign w_last_load = (r_beat_cnt == CW'(Beats - 1));
    assign w_done      = (r_state == DRAIN) & w_xfer & r_m_last & ~clear;

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (cat_valid) w_next = STREAM;
            end
            STREAM: begin
                w_rd_en = ~r_m_valid | m_ready;
                if (w_rd_en && w_last_load) w_next = DRAIN;
            end
            DRAIN: begin
                if (w_xfer && r_m_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Abort wins over any load, transfer or transition this cycle
        if (clear) begin
            w_next  = IDLE;
            w_rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_m_data    <= '0;
            r_vec_count <= '0;
        end else if (clear) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && cat_valid) r_beat_cnt <= '0;
            if (w_rd_en) begin
                r_m_data   <= rd_data;
                r_m_valid  <= 1'b1;
                r_m_last   <= w_last_load;
                r_beat_cnt <= r_beat_cnt + CW'(1);
            end else if (w_xfer) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
            if (w_done) r_vec_count <= r_vec_count + 16'd1;
        end
    end

    assign rd_en     = w_rd_en;
    assign m_valid   = r_m_valid;
    assign m_last    = r_m_last;
    assign m_data    = r_m_data;
    assign vec_count = r_vec_count;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_cat_read_sequencer.sv
// Directed bench for cat_read_sequencer with NBits=8, VecElements=6,
// ElementsPerRead=2 (three beats per vector).
module tb_cat_read_sequencer;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b0;
    logic            cat_valid = 1'b0;
    logic            rd_en;
    logic [1:0][7:0] rd_data = '0;
    logic            clear = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [1:0][7:0] m_data;
    logic            m_last;
    logic [15:0]     vec_count;
    logic            busy;

    int checks = 0;
    int failures = 0;

    logic [15:0] up_mem [6] = '{16'h0201, 16'h0403, 16'h0605,
                                16'h0807, 16'h0A09, 16'h0C0B};
    int idx = 0;

    int cv_s [16];
    int mr_s [16];
    int cl_s [16];
    int lg_rd [16];
    int lg_mv [16];
    int lg_ml [16];
    int lg_bz [16];
    int lg_vc [16];
    logic [15:0] lg_md [16];

    cat_read_sequencer #(
        .NBits(8),
        .VecElements(6),
        .ElementsPerRead(2)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .cat_valid(cat_valid),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .clear(clear),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_last(m_last),
        .vec_count(vec_count),
        .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr_stim();
        for (int k = 0; k < 16; k++) begin
            cv_s[k] = 0;
            mr_s[k] = 1;
            cl_s[k] = 0;
        end
    endtask

    // Upstream buffer model: window advances on each rd_en edge
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            cat_valid = cv_s[k][0];
            m_ready   = mr_s[k][0];
            clear     = cl_s[k][0];
            rd_data   = up_mem[idx];
            #1;
            lg_rd[k] = int'(rd_en);
            lg_mv[k] = int'(m_valid);
            lg_ml[k] = int'(m_last);
            lg_bz[k] = int'(busy);
            lg_vc[k] = int'(vec_count);
            lg_md[k] = m_data;
            @(posedge clk_in);
            if (lg_rd[k] != 0) idx = (idx + 1) % 6;
            if (cl_s[k] != 0) idx = 0;
            #1;
        end
        cat_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic do_reset();
        rst_in    = 1'b0;
        cat_valid = 1'b0;
        clear     = 1'b0;
        m_ready   = 1'b0;
        idx       = 0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        cat_valid = 1'b1;
        m_ready = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if ({m_valid, m_last, busy, rd_en} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000",
                     {m_valid, m_last, busy, rd_en});
        end
        checks++;
        if (m_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data got=%h want=0000", m_data);
        end
        checks++;
        if (vec_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_vc got=%0d want=0", vec_count);
        end
        do_reset();
    endtask

    task automatic test_basic();
        int e_rd [6] = '{0, 1, 1, 1, 0, 0};
        int e_mv [6] = '{0, 0, 1, 1, 1, 0};
        int e_ml [6] = '{0, 0, 0, 0, 1, 0};
        int e_bz [6] = '{0, 1, 1, 1, 1, 0};
        int e_vc [6] = '{0, 0, 0, 0, 0, 1};
        logic [15:0] e_md [6] = '{0, 0, 16'h0201, 16'h0403, 16'h0605, 0};
        do_reset();
        clr_stim();
        for (int k = 0; k < 4; k++) cv_s[k] = 1;
        run(6);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (lg_rd[k] != e_rd[k] || lg_mv[k] != e_mv[k] ||
                lg_ml[k] != e_ml[k] || lg_bz[k] != e_bz[k]) begin
                failures++;
                $display("FAIL basic_ctl c%0d got rd/mv/ml/bz=%0d%0d%0d%0d want=%0d%0d%0d%0d",
                         k, lg_rd[k], lg_mv[k], lg_ml[k], lg_bz[k],
                         e_rd[k], e_mv[k], e_ml[k], e_bz[k]);
            end
            checks++;
            if (lg_vc[k] != e_vc[k]) begin
                failures++;
                $display("FAIL basic_vc c%0d got=%0d want=%0d", k, lg_vc[k], e_vc[k]);
            end
            if (e_mv[k] != 0) begin
                checks++;
                if (lg_md[k] !== e_md[k]) begin
                    failures++;
                    $display("FAIL basic_data c%0d got=%h want=%h", k, lg_md[k], e_md[k]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int e_rd [10] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        int e_mv [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        int e_ml [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        int e_vc [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        logic [15:0] e_md [10] = '{0, 0, 16'h0201, 16'h0201, 16'h0201,
                                   16'h0201, 16'h0201, 16'h0403, 16'h0605, 0};
        do_reset();
        clr_stim();
        cv_s[0] = 1;
        for (int k = 2; k < 6; k++) mr_s[k] = 0;
        run(10);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (lg_rd[k] != e_rd[k] || lg_mv[k] != e_mv[k] || lg_ml[k] != e_ml[k]) begin
                failures++;
                $display("FAIL stall_ctl c%0d got rd/mv/ml=%0d%0d%0d want=%0d%0d%0d",
                         k, lg_rd[k], lg_mv[k], lg_ml[k], e_rd[k], e_mv[k], e_ml[k]);
            end
            checks++;
            if (lg_vc[k] != e_vc[k]) begin
                failures++;
                $display("FAIL stall_vc c%0d got=%0d want=%0d", k, lg_vc[k], e_vc[k]);
            end
            if (e_mv[k] != 0) begin
                checks++;
                if (lg_md[k] !== e_md[k]) begin
                    failures++;
                    $display("FAIL stall_data c%0d got=%h want=%h", k, lg_md[k], e_md[k]);
                end
            end
        end
    endtask

    task automatic test_cat_drop();
        int e_rd [6] = '{0, 1, 1, 1, 0, 0};
        int e_ml [6] = '{0, 0, 0, 0, 1, 0};
        logic [15:0] e_md [6] = '{0, 0, 16'h0201, 16'h0403, 16'h0605, 0};
        do_reset();
        clr_stim();
        cv_s[0] = 1;
        cv_s[1] = 1;
        run(6);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (lg_rd[k] != e_rd[k] || lg_ml[k] != e_ml[k]) begin
                failures++;
                $display("FAIL drop_ctl c%0d got rd/ml=%0d%0d want=%0d%0d",
                         k, lg_rd[k], lg_ml[k], e_rd[k], e_ml[k]);
            end
            if (k >= 2 && k <= 4) begin
                checks++;
                if (lg_md[k] !== e_md[k] || lg_mv[k] != 1) begin
                    failures++;
                    $display("FAIL drop_data c%0d got=%h mv=%0d want=%h mv=1",
                             k, lg_md[k], lg_mv[k], e_md[k]);
                end
            end
        end
        checks++;
        if (lg_vc[5] != 1) begin
            failures++;
            $display("FAIL drop_vc got=%0d want=1", lg_vc[5]);
        end
    endtask

    task automatic test_clear();
        int e_rd [11] = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0};
        int e_mv [11] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0};
        int e_ml [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        int e_bz [11] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
        int e_vc [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        logic [15:0] e_md [11] = '{0, 0, 16'h0201, 16'h0403, 0, 0, 0,
                                   16'h0201, 16'h0403, 16'h0605, 0};
        do_reset();
        clr_stim();
        cv_s[0] = 1;
        cv_s[5] = 1;
        cl_s[3] = 1;
        run(11);
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (lg_rd[k] != e_rd[k] || lg_mv[k] != e_mv[k] ||
                lg_ml[k] != e_ml[k] || lg_bz[k] != e_bz[k]) begin
                failures++;
                $display("FAIL clear_ctl c%0d got rd/mv/ml/bz=%0d%0d%0d%0d want=%0d%0d%0d%0d",
                         k, lg_rd[k], lg_mv[k], lg_ml[k], lg_bz[k],
                         e_rd[k], e_mv[k], e_ml[k], e_bz[k]);
            end
            checks++;
            if (lg_vc[k] != e_vc[k]) begin
                failures++;
                $display("FAIL clear_vc c%0d got=%0d want=%0d", k, lg_vc[k], e_vc[k]);
            end
            if (e_mv[k] != 0) begin
                checks++;
                if (lg_md[k] !== e_md[k]) begin
                    failures++;
                    $display("FAIL clear_data c%0d got=%h want=%h", k, lg_md[k], e_md[k]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        // Continues from a delivered vector so vec_count starts at 1
        idx = 0;
        clr_stim();
        cv_s[0] = 1;
        mr_s[4] = 0;
        mr_s[5] = 0;
        run(5);
        m_ready = 1'b0;
        checks++;
        if ({m_valid, m_last, busy} !== 3'b111 || vec_count !== 16'd1) begin
            failures++;
            $display("FAIL areset_pre got mv/ml/bz=%b vc=%0d want=111 vc=1",
                     {m_valid, m_last, busy}, vec_count);
        end
        #3;
        rst_in = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_last, busy, rd_en} !== 4'b0000) begin
            failures++;
            $display("FAIL areset_flags got=%b want=0000",
                     {m_valid, m_last, busy, rd_en});
        end
        checks++;
        if (vec_count !== 16'd0) begin
            failures++;
            $display("FAIL areset_vc got=%0d want=0", vec_count);
        end
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if ({m_valid, busy, rd_en} !== 3'b000) begin
            failures++;
            $display("FAIL areset_idle got mv/bz/rd=%b want=000",
                     {m_valid, busy, rd_en});
        end
    endtask

    task automatic test_back_to_back();
        int e_rd [11] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
        int e_mv [11] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0};
        int e_ml [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        int e_bz [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int e_vc [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2};
        logic [15:0] e_md [11] = '{0, 0, 16'h0201, 16'h0403, 16'h0605, 0,
                                   0, 16'h0807, 16'h0A09, 16'h0C0B, 0};
        do_reset();
        clr_stim();
        for (int k = 0; k < 11; k++) cv_s[k] = 1;
        run(11);
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (lg_rd[k] != e_rd[k] || lg_mv[k] != e_mv[k] ||
                lg_ml[k] != e_ml[k] || lg_bz[k] != e_bz[k]) begin
                failures++;
                $display("FAIL b2b_ctl c%0d got rd/mv/ml/bz=%0d%0d%0d%0d want=%0d%0d%0d%0d",
                         k, lg_rd[k], lg_mv[k], lg_ml[k], lg_bz[k],
                         e_rd[k], e_mv[k], e_ml[k], e_bz[k]);
            end
            checks++;
            if (lg_vc[k] != e_vc[k]) begin
                failures++;
                $display("FAIL b2b_vc c%0d got=%0d want=%0d", k, lg_vc[k], e_vc[k]);
            end
            if (e_mv[k] != 0) begin
                checks++;
                if (lg_md[k] !== e_md[k]) begin
                    failures++;
                    $display("FAIL b2b_data c%0d got=%h want=%h", k, lg_md[k], e_md[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_cat_drop();
        test_async_reset();
        test_clear();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cat_read_sequencer.md
CAT_READ_SEQUENCER -- requirements
Module: cat_read_sequencer

Interface
REQ-001 Parameter NBits, default 8: element width in bits.
REQ-002 Parameter VecElements, default 6: total elements in one concatenated vector held by the upstream cat2 buffer.
REQ-003 Parameter ElementsPerRead, default 2: elements per upstream read and per output beat; VecElements SHALL be an integer multiple of ElementsPerRead.
REQ-004 Derived constant Beats = VecElements/ElementsPerRead; counters SHALL be $clog2(Beats)+1 bits wide.
REQ-005 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_in  input  1  reset, asynchronous, active-low.
REQ-007 cat_valid  input  1  upstream concatenated vector complete.
REQ-008 rd_en  output  1  upstream read advance, combinational.
REQ-009 rd_data  input  [ElementsPerRead-1:0][NBits-1:0]  upstream read window, valid in the same cycle as rd_en.
REQ-010 clear  input  1  synchronous abort of the current vector.
REQ-011 m_valid  output  1  output beat valid, registered.
REQ-012 m_ready  input  1  downstream accepts beat.
REQ-013 m_data  output  [ElementsPerRead-1:0][NBits-1:0]  output beat, registered.
REQ-014 m_last  output  1  registered; high with the final beat of a vector.
REQ-015 vec_count  output  16  vectors fully delivered, wraps at 2^16.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, STREAM, DRAIN.
REQ-018 IDLE -> STREAM on the first cycle cat_valid=1; beat_cnt loads 0.
REQ-019 In STREAM, rd_en SHALL be 1 exactly when (m_valid=0 or m_ready=1); rd_en SHALL be 0 in IDLE and DRAIN.
REQ-020 On each rd_en cycle: m_data <= rd_data, m_valid <= 1, beat_cnt increments, m_last <= (beat_cnt == Beats-1).
REQ-021 Latency: one cycle from rd_en high to the captured data on m_data with m_valid=1.
REQ-022 STREAM -> DRAIN on the rd_en cycle that loads beat Beats-1.
REQ-023 A beat transfers when m_valid=1 and m_ready=1; if no new load occurs that cycle, m_valid <= 0 and m_last <= 0.
REQ-024 While m_valid=1 and m_ready=0, m_data, m_last and m_valid SHALL hold; no rd_en issued.
REQ-025 DRAIN -> IDLE on transfer of the beat with m_last=1; vec_count increments in that same cycle.
REQ-026 cat_valid falling during STREAM or DRAIN SHALL be ignored; it is sampled only in IDLE.
REQ-027 With m_ready held 1, Beats consecutive rd_en cycles occur with no bubbles; the next vector starts no earlier than the cycle after the DRAIN->IDLE transition.
REQ-028 clear=1 in any state: next state IDLE, m_valid <= 0, m_last <= 0, beat_cnt <= 0, rd_en forced 0 that cycle, vec_count unchanged; clear overrides every simultaneous event.
REQ-029 Simultaneous transfer and load in STREAM (m_valid=1, m_ready=1, rd_en=1): the new beat replaces the old one and m_valid stays 1.

Reset
REQ-030 rst_in low asynchronously forces state IDLE, beat_cnt 0, m_valid 0, m_last 0, m_data 0, vec_count 0; rd_en and busy read 0 while reset is held.
REQ-031 Reset asserted mid-vector discards partial output; after release the block waits for cat_valid in IDLE.

Verification (NBits=8, VecElements=6, ElementsPerRead=2, Beats=3)
REQ-032 cat_valid=1, m_ready=1, rd_data={0x02,0x01},{0x04,0x03},{0x06,0x05} on successive rd_en cycles -> rd_en high 3 consecutive cycles; m_data shows the same three beats one cycle later; m_last only on {0x06,0x05}; vec_count 0->1.
REQ-033 Same stimulus with m_ready=0 for 4 cycles after the first beat -> m_data holds {0x02,0x01}, rd_en 0 during the stall, then beats 2 and 3 follow in order.
REQ-034 cat_valid drops to 0 one cycle after STREAM entry -> all 3 beats still delivered, vec_count=1.
REQ-035 clear=1 after beat 2 is loaded -> m_valid 0 next cycle, state IDLE, vec_count stays 0, next cat_valid restarts with beat_cnt=0.
REQ-036 rst_in low for 1 cycle during DRAIN, asynchronous to the clock edge -> m_valid, m_last and busy go 0 immediately, vec_count=0.
REQ-037 cat_valid held 1 continuously with m_ready=1 -> 3 rd_en cycles, 1 idle cycle, then the next 3, with vec_count incrementing once per vector.
